// File: rtl/spi_minion_channel_adapter.sv
// SPI minion adapter fanning packets out to per-channel master-to-chip queues and
// round-robin merging per-channel chip-to-master queues back onto the SPI pull side.
module spi_minion_channel_adapter #(
  parameter int unsigned nbits        = 8,
  parameter int unsigned num_entries  = 2,
  parameter int unsigned num_channels = 4
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic                                                        pull_en,
  output logic                                                        pull_msg_val,
  output logic                                                        pull_msg_spc,
  output logic [nbits-3:0]                                            pull_msg_data,
  input  logic                                                        push_en,
  input  logic                                                        push_msg_val_wrt,
  input  logic                                                        push_msg_val_rd,
  input  logic [nbits-3:0]                                            push_msg_data,
  output logic [num_channels*(nbits-2-$clog2(num_channels))-1:0]      send_msg,
  output logic [num_channels-1:0]                                     send_val,
  input  logic [num_channels-1:0]                                     send_rdy,
  input  logic [num_channels*(nbits-2-$clog2(num_channels))-1:0]      recv_msg,
  input  logic [num_channels-1:0]                                     recv_val,
  output logic [num_channels-1:0]                                     recv_rdy,
  output logic [num_channels-1:0]                                     overflow
);

  localparam int unsigned abits = $clog2(num_channels);
  localparam int unsigned dbits = nbits - 2 - abits;
  localparam int unsigned cbits = $clog2(num_entries + 1);
  localparam int unsigned pbits = (num_entries > 1) ? $clog2(num_entries) : 1;
  // Queues 0..num_channels-1 are MC, num_channels..2*num_channels-1 are CM.
  localparam int unsigned nq    = 2 * num_channels;

  logic [nq-1:0]                       q_enq, q_deq, q_full, q_ne;
  logic [nq-1:0][dbits-1:0]            q_wdata, q_head;
  logic [num_channels-1:0][dbits-1:0]  cm_head;
  logic [num_channels-1:0]             cm_ne;
  logic                                cm_any;

  logic [abits-1:0]        rr_ptr_q, grant;
  logic [num_channels-1:0] overflow_q;

  logic             wr_go, rd_go, clr;
  logic [abits-1:0] wr_addr;
  logic [dbits-1:0] wr_payload;

  // Pull enable only opens the SPI load window; nothing here reacts to it.
  logic unused_pull_en;
  assign unused_pull_en = pull_en;

  assign wr_addr    = push_msg_data[nbits-3 -: abits];
  assign wr_payload = push_msg_data[dbits-1:0];
  assign wr_go      = push_en & push_msg_val_wrt;
  assign rd_go      = push_en & push_msg_val_rd & cm_any;
  assign clr        = push_en & ~push_msg_val_wrt & ~push_msg_val_rd;

  assign cm_ne   = q_ne[nq-1:num_channels];
  assign cm_head = q_head[nq-1:num_channels];
  assign cm_any  = |cm_ne;

  // Scan from the far end so the channel nearest rr_ptr wins.
  always_comb begin
    grant = '0;
    for (int k = int'(num_channels) - 1; k >= 0; k--) begin
      if (cm_ne[rr_ptr_q + abits'(k)]) grant = rr_ptr_q + abits'(k);
    end
  end

  for (genvar i = 0; i < num_channels; i++) begin : g_route
    assign q_enq[i]                = wr_go && (wr_addr == abits'(i)) && !q_full[i];
    assign q_wdata[i]              = wr_payload;
    assign q_deq[i]                = q_ne[i] && send_rdy[i];
    assign q_enq[num_channels+i]   = recv_val[i] && recv_rdy[i];
    assign q_wdata[num_channels+i] = recv_msg[i*dbits +: dbits];
    assign q_deq[num_channels+i]   = rd_go && (grant == abits'(i));
  end

  for (genvar q = 0; q < nq; q++) begin : g_queue
    logic [dbits-1:0] mem_q [num_entries];
    logic [pbits-1:0] wp_q, rp_q;
    logic [cbits-1:0] cnt_q;

    assign q_full[q] = (cnt_q == cbits'(num_entries));
    assign q_ne[q]   = (cnt_q != '0);
    assign q_head[q] = mem_q[rp_q];

    always_ff @(posedge clk) begin
      if (reset) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (q_enq[q]) wp_q <= (wp_q == pbits'(num_entries - 1)) ? '0 : wp_q + pbits'(1);
        if (q_deq[q]) rp_q <= (rp_q == pbits'(num_entries - 1)) ? '0 : rp_q + pbits'(1);
        cnt_q <= cnt_q + cbits'(q_enq[q]) - cbits'(q_deq[q]);
      end
    end

    always_ff @(posedge clk) begin
      if (q_enq[q]) mem_q[wp_q] <= q_wdata[q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      overflow_q <= '0;
    end else begin
      if (rd_go) rr_ptr_q <= grant + abits'(1);
      if (clr) overflow_q <= '0;
      else if (wr_go && q_full[wr_addr]) overflow_q[wr_addr] <= 1'b1;
    end
  end

  // Outputs are forced quiet while reset is held so stale state never leaks.
  assign send_val      = reset ? '0 : q_ne[num_channels-1:0];
  assign send_msg      = q_head[num_channels-1:0];
  assign recv_rdy      = reset ? '0 : ~q_full[nq-1:num_channels];
  assign pull_msg_val  = !reset && cm_any;
  assign pull_msg_spc  = !reset && !(|q_full[num_channels-1:0]);
  assign pull_msg_data = (reset || !cm_any) ? '0 : {grant, cm_head[grant]};
  assign overflow      = reset ? '0 : overflow_q;

endmodule

// File: tb/tb_spi_minion_channel_adapter.sv
// Randomized and directed bench for spi_minion_channel_adapter against a queue-based model
// (nbits=8, num_channels=4, num_entries=2).
module tb_spi_minion_channel_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pull_en;
  logic        pull_msg_val, pull_msg_spc;
  logic [5:0]  pull_msg_data;
  logic        push_en, push_msg_val_wrt, push_msg_val_rd;
  logic [5:0]  push_msg_data;
  logic [15:0] send_msg;
  logic [3:0]  send_val, send_rdy;
  logic [15:0] recv_msg;
  logic [3:0]  recv_val, recv_rdy, overflow;

  int checks = 0;
  int errors = 0;

  logic [3:0] mc_m [4][$];
  logic [3:0] cm_m [4][$];
  int         rr_m;
  logic [3:0] ovf_m;

  spi_minion_channel_adapter #(
    .nbits(8),
    .num_entries(2),
    .num_channels(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pull_en(pull_en),
    .pull_msg_val(pull_msg_val),
    .pull_msg_spc(pull_msg_spc),
    .pull_msg_data(pull_msg_data),
    .push_en(push_en),
    .push_msg_val_wrt(push_msg_val_wrt),
    .push_msg_val_rd(push_msg_val_rd),
    .push_msg_data(push_msg_data),
    .send_msg(send_msg),
    .send_val(send_val),
    .send_rdy(send_rdy),
    .recv_msg(recv_msg),
    .recv_val(recv_val),
    .recv_rdy(recv_rdy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    for (int k = 0; k < 4; k++) begin
      if (cm_m[(rr_m + k) % 4].size() > 0) return (rr_m + k) % 4;
    end
    return 0;
  endfunction

  function automatic bit m_any();
    return (cm_m[0].size() + cm_m[1].size() + cm_m[2].size() + cm_m[3].size()) > 0;
  endfunction

  task automatic model_check();
    logic [3:0] e_sv, e_rr;
    logic       e_spc;
    logic [5:0] e_data;
    int         g;
    e_spc = !reset;
    for (int i = 0; i < 4; i++) begin
      e_sv[i] = !reset && (mc_m[i].size() > 0);
      e_rr[i] = !reset && (cm_m[i].size() < 2);
      if (mc_m[i].size() >= 2) e_spc = 1'b0;
    end
    chk("send_val", 32'(send_val), 32'(e_sv));
    for (int i = 0; i < 4; i++) begin
      if (e_sv[i]) chk("send_msg", 32'(send_msg[i*4 +: 4]), 32'(mc_m[i][0]));
    end
    chk("recv_rdy", 32'(recv_rdy), 32'(e_rr));
    chk("pull_msg_spc", 32'(pull_msg_spc), 32'(e_spc));
    chk("pull_msg_val", 32'(pull_msg_val), 32'(!reset && m_any()));
    e_data = '0;
    if (!reset && m_any()) begin
      g = m_grant();
      e_data = {2'(g), cm_m[g][0]};
    end
    chk("pull_msg_data", 32'(pull_msg_data), 32'(e_data));
    chk("overflow", 32'(overflow), reset ? 32'd0 : 32'(ovf_m));
  endtask

  task automatic model_step();
    bit   mc_full [4], mc_ne [4], cm_full [4];
    bit   pv;
    int   g, a;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mc_m[i].delete();
        cm_m[i].delete();
      end
      rr_m  = 0;
      ovf_m = '0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      mc_full[i] = mc_m[i].size() >= 2;
      mc_ne[i]   = mc_m[i].size() > 0;
      cm_full[i] = cm_m[i].size() >= 2;
    end
    pv = m_any();
    g  = m_grant();
    a  = int'(push_msg_data[5:4]);
    for (int i = 0; i < 4; i++) begin
      if (mc_ne[i] && send_rdy[i]) void'(mc_m[i].pop_front());
    end
    if (push_en && push_msg_val_rd && pv) begin
      void'(cm_m[g].pop_front());
      rr_m = (g + 1) % 4;
    end
    if (push_en && push_msg_val_wrt) begin
      if (!mc_full[a]) mc_m[a].push_back(push_msg_data[3:0]);
      else ovf_m[a] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (recv_val[i] && !cm_full[i]) cm_m[i].push_back(recv_msg[i*4 +: 4]);
    end
    if (push_en && !push_msg_val_wrt && !push_msg_val_rd) ovf_m = '0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    pull_en          = 1'b0;
    push_en          = 1'b0;
    push_msg_val_wrt = 1'b0;
    push_msg_val_rd  = 1'b0;
    push_msg_data    = '0;
    send_rdy         = '0;
    recv_val         = '0;
    recv_msg         = '0;
  endtask

  task automatic push(input logic wrt, input logic rd, input logic [5:0] data);
    push_en          = 1'b1;
    push_msg_val_wrt = wrt;
    push_msg_val_rd  = rd;
    push_msg_data    = data;
    tick();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rr_m  = 0;
    ovf_m = '0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_send_val", 32'(send_val), 32'h0);
    chk("rst_recv_rdy", 32'(recv_rdy), 32'hF);
    chk("rst_pull_val", 32'(pull_msg_val), 32'h0);
    chk("rst_pull_spc", 32'(pull_msg_spc), 32'h1);
    chk("rst_overflow", 32'(overflow), 32'h0);
    tick();

    // Write routing to channel 2
    push(1'b1, 1'b0, {2'd2, 4'hA});
    #1;
    chk("wr_send_val", 32'(send_val), 32'h4);
    chk("wr_send_msg", 32'(send_msg[11:8]), 32'hA);
    send_rdy = 4'b0100;
    tick();
    idle();
    #1;
    chk("wr_drained", 32'(send_val), 32'h0);

    // Overflow on channel 1 and clear
    push(1'b1, 1'b0, {2'd1, 4'h1});
    push(1'b1, 1'b0, {2'd1, 4'h2});
    push(1'b1, 1'b0, {2'd1, 4'h3});
    #1;
    chk("ovf_set", 32'(overflow), 32'h2);
    chk("ovf_spc", 32'(pull_msg_spc), 32'h0);
    send_rdy = 4'b0010;
    #1;
    chk("ovf_head1", 32'(send_msg[7:4]), 32'h1);
    tick();
    #1;
    chk("ovf_head2", 32'(send_msg[7:4]), 32'h2);
    tick();
    idle();
    push(1'b0, 1'b0, 6'h00);
    #1;
    chk("ovf_clear", 32'(overflow), 32'h0);

    // Round-robin across channels 0 and 3, then wrap
    recv_val = 4'b1001;
    recv_msg = 16'h6005;
    tick();
    idle();
    #1;
    chk("rr_val", 32'(pull_msg_val), 32'h1);
    chk("rr_first", 32'(pull_msg_data), 32'h05);
    push(1'b0, 1'b1, 6'h00);
    #1;
    chk("rr_second", 32'(pull_msg_data), 32'h36);
    push(1'b0, 1'b1, 6'h00);
    #1;
    chk("rr_empty", 32'(pull_msg_val), 32'h0);
    recv_val = 4'b0101;
    recv_msg = 16'h0807;
    tick();
    idle();
    #1;
    chk("rr_wrap", 32'(pull_msg_data), 32'h07);
    push(1'b0, 1'b1, 6'h00);
    #1;
    chk("rr_next", 32'(pull_msg_data), 32'h28);
    push(1'b0, 1'b1, 6'h00);

    // Read ack with nothing to pull
    push(1'b0, 1'b1, 6'h00);
    recv_val = 4'b0010;
    recv_msg = 16'h0090;
    tick();
    idle();
    #1;
    chk("empty_ack_grant", 32'(pull_msg_data), 32'h19);
    push(1'b0, 1'b1, 6'h00);

    // Backpressure on CM[0], then reset with MC[3] full
    recv_val = 4'b0001;
    recv_msg = 16'h000C;
    tick();
    tick();
    idle();
    #1;
    chk("bp_full", 32'(recv_rdy), 32'hE);
    push(1'b0, 1'b1, 6'h00);
    #1;
    chk("bp_free", 32'(recv_rdy), 32'hF);
    push(1'b1, 1'b0, {2'd3, 4'h1});
    push(1'b1, 1'b0, {2'd3, 4'h2});
    #1;
    chk("mid_send_val", 32'(send_val), 32'h8);
    reset = 1'b1;
    #1;
    chk("in_rst_send_val", 32'(send_val), 32'h0);
    chk("in_rst_recv_rdy", 32'(recv_rdy), 32'h0);
    chk("in_rst_pull_data", 32'(pull_msg_data), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_send_val", 32'(send_val), 32'h0);
    chk("post_rst_pull_val", 32'(pull_msg_val), 32'h0);
    chk("post_rst_recv_rdy", 32'(recv_rdy), 32'hF);
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset            = ($urandom_range(0, 149) == 0);
      pull_en          = 1'($urandom);
      push_en          = ($urandom_range(0, 2) == 0);
      push_msg_val_wrt = 1'($urandom);
      push_msg_val_rd  = 1'($urandom);
      push_msg_data    = 6'($urandom);
      send_rdy         = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      recv_val         = 4'($urandom);
      recv_msg         = 16'($urandom);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_minion_channel_adapter.md
# spi_minion_channel_adapter

Multi-channel successor to the single-stream SPI minion adapter. Sits between the SPI minion push/pull interface and `num_channels` independent val/rdy stream pairs on the chip side. An address field in each SPI packet steers writes to a per-channel master-to-chip (MC) queue. Reads drain per-channel chip-to-master (CM) queues through a round-robin arbiter, and a per-channel sticky overflow flag is kept for each MC queue.

## Interface
- `nbits`, 8: SPI packet width, including the two flag bits (val_wrt, val_rd).
- `num_entries`, 2: depth of every MC and CM queue; ≥1.
- `num_channels`, 4: channel count; a power of two, ≥2.
- Derived `abits` = $clog2(num_channels); derived `dbits` = nbits-2-abits, which must be ≥1.

Ports, clock and reset first:
- `clk`  in  1  single clock; all state on posedge.
- `reset`  in  1  synchronous, active-high.
- `pull_en`  in  1  SPI minion is loading its shift register this cycle.
- `pull_msg_val`  out  1  a CM payload is available.
- `pull_msg_spc`  out  1  every MC queue has at least one free slot.
- `pull_msg_data`  out  nbits-2  {grant channel [abits], CM head payload [dbits]}.
- `push_en`  in  1  SPI minion has completed a received packet.
- `push_msg_val_wrt`  in  1  packet is a write.
- `push_msg_val_rd`  in  1  packet acknowledges a read (dequeue).
- `push_msg_data`  in  nbits-2  {channel addr [abits], payload [dbits]}.
- `send_msg`  out  num_channels*dbits  MC head payloads; channel i occupies bits [i*dbits +: dbits].
- `send_val`  out  num_channels  MC queue i is non-empty.
- `send_rdy`  in  num_channels  chip consumes from channel i.
- `recv_msg`  in  num_channels*dbits  CM payloads, packed the same way as `send_msg`.
- `recv_val`  in  num_channels  chip offers data on channel i.
- `recv_rdy`  out  num_channels  CM queue i is not full.
- `overflow`  out  num_channels  sticky flag: a write to MC queue i was dropped.

## Operation
- Queues are normal FIFOs, not bypass. An enqueued entry becomes visible at the head on the next cycle.
- Full and empty are evaluated on cycle-start state. A dequeue in the same cycle does not free a slot for an enqueue.
- **Write**: when `push_en && push_msg_val_wrt`, with addr = push_msg_data[nbits-3 -: abits]:
  - If MC[addr] is not full, enqueue the payload.
  - If it is full, drop the payload and set overflow[addr] <= 1.
- **Read ack**: when `push_en && push_msg_val_rd && pull_msg_val`:
  - Dequeue CM[grant].
  - Advance the pointer: rr_ptr <= (grant+1) mod num_channels.
  - Read ack with `pull_msg_val`=0 is ignored; no state changes.
- **Write and read ack together**: when both flags are set, both actions occur in the same cycle.
- **Clear**: when `push_en` is asserted with both flags at 0, all overflow bits are cleared in that cycle.
- **Arbiter** (combinational from state):
  - grant = first channel j with a non-empty CM queue, searching j = rr_ptr, rr_ptr+1, … mod num_channels.
  - `pull_msg_val` = OR of all CM non-empty signals.
  - `pull_msg_data` = {grant, CM[grant] head}. When `pull_msg_val`=0 the data is don't-care; drive it to 0.
- **Pull timing**: `pull_en` has no side effects. Data must be stable from `pull_en` until the matching read ack. The arbiter changes grant only on a read ack or a CM enqueue, and the SPI protocol guarantees the window.
- **Chip side, per channel**:
  - CM[i] enqueues on recv_val[i] && recv_rdy[i].
  - MC[i] dequeues on send_val[i] && send_rdy[i].
- **Arithmetic**: queue pointers wrap modulo num_entries. Occupancy counters are $clog2(num_entries+1) bits wide. rr_ptr is abits wide and wraps naturally.

## Timing
- **Reset** (1 cycle minimum), all queues empty, rr_ptr=0, overflow=0.
  - While reset is high: send_val=0, recv_rdy=0, pull_msg_val=0, pull_msg_spc=0, pull_msg_data=0.
  - First cycle after reset: recv_rdy=all 1, pull_msg_spc=1.
- **Reset mid-operation**: all contents are discarded and overflow is cleared. No output may carry stale data in the cycle after reset falls.
- **Write → send_val**: 1 cycle.
- **recv handshake → pull_msg_val**: 1 cycle.
- **Read ack → next grant**: 1 cycle.
- `pull_msg_spc` is registered-state-derived and deasserts the cycle after any MC queue becomes full.
- `recv_rdy[i]` deasserts the cycle after CM[i] becomes full and reasserts the cycle after a dequeue from it.
- **Overflow**: set 1 cycle after the dropped write. Clear has priority over set when both occur in the same push; that cannot happen because they require different flag values.

## Test plan
All scenarios use nbits=8, num_channels=4, num_entries=2, giving abits=2 and dbits=4.
1. **Reset**: assert reset for 2 cycles, then release → send_val=0000, recv_rdy=1111, pull_msg_val=0, pull_msg_spc=1, overflow=0000.
2. **Write routing**: push write {2'd2, 4'hA}, with send_rdy=0 → next cycle send_val=0100 and send_msg[11:8]=A; then send_rdy[2]=1 → send_val=0000 the following cycle.
3. **Overflow and clear**: three writes of 4'h1, 4'h2, 4'h3 to ch1, with send_rdy=0 → the third is dropped; overflow=0010 and pull_msg_spc=0. Drain ch1 → payloads 1, then 2. Push with both flags 0 → overflow=0000.
4. **Round-robin**: recv 4'h5 on ch0 and 4'h6 on ch3 in the same cycle → pull_msg_data={0,5}. After the read ack → {3,6}. After the next read ack → pull_msg_val=0, and rr_ptr wraps to 0.
5. **Read ack with CM empty**: read ack while pull_msg_val=0 → no state change; a subsequent recv on ch1 yields grant=1.
6. **Backpressure and reset mid-operation**: fill CM[0] with two entries → recv_rdy[0]=0. Read ack → recv_rdy[0]=1 next cycle. Assert reset with MC[3] holding 2 entries → send_val=0000 and all queues empty after release.
